signed_addsub_pipe: RTL and testbench

//  Parametrised pipelined signed add/subtract unit for the signed calculator datapath.

---
 rtl/signed_addsub_pipe_pkg.sv | 9 +
 rtl/addsub_chunk.sv | 30 +++
 rtl/signed_addsub_pipe.sv | 143 ++++++++++++++
 tb/tb_signed_addsub_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_addsub_pipe_pkg.sv
// Shared definitions for the pipelined signed add/subtract unit.
package signed_addsub_pipe_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder slice; also exposes the carry into its MSB,
// which the final slice uses for signed overflow.
module addsub_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK:0] c;

    // NOTE: every combinational output gets a default before the loop so no latch can be inferred.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout    = c[CHUNK];
    assign msb_cin = c[CHUNK - 1];

endmodule

// File: rtl/signed_addsub_pipe.sv
// Pipelined signed add/subtract: one CHUNK-bit slice resolved per stage, carry registered
// between stages, valid/ready handshake with a bubble-collapsing advance chain.
module signed_addsub_pipe
    import signed_addsub_pipe_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             ovf,
    output logic             cb,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic              op_sub;
    logic [STAGES:0]   adv;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] op_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q    [STAGES];
    logic [WIDTH-1:0]  beff_q [STAGES];
    logic [WIDTH-1:0]  res_q  [STAGES];
    logic              ovf_q;
    logic              zero_q;

    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_op;
    logic [STAGES-1:0] stage_cin;
    logic [WIDTH-1:0]  stage_a    [STAGES];
    logic [WIDTH-1:0]  stage_beff [STAGES];
    logic [WIDTH-1:0]  stage_res  [STAGES];
    logic [WIDTH-1:0]  res_d      [STAGES];

    logic [CHUNK-1:0]  sum_w  [STAGES];
    logic [STAGES-1:0] cout_w;
    logic              msbc_w [STAGES];

    assign op_sub = (op_e'(op) == OP_SUB);

    // Stage 0 sees the port operands with B inverted for subtraction; later stages see the previous registers.
    always_comb begin
        stage_valid[0] = in_valid;
        stage_op[0]    = op;
        stage_cin[0]   = op_sub;
        stage_a[0]     = a;
        stage_beff[0]  = b ^ {WIDTH{op_sub}};
        stage_res[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            stage_valid[k] = valid_q[k - 1];
            stage_op[k]    = op_q[k - 1];
            stage_cin[k]   = carry_q[k - 1];
            stage_a[k]     = a_q[k - 1];
            stage_beff[k]  = beff_q[k - 1];
            stage_res[k]   = res_q[k - 1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .x       (stage_a[k][k*CHUNK +: CHUNK]),
            .y       (stage_beff[k][k*CHUNK +: CHUNK]),
            .cin     (stage_cin[k]),
            .s       (sum_w[k]),
            .cout    (cout_w[k]),
            .msb_cin (msbc_w[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            res_d[k]                    = stage_res[k];
            res_d[k][k*CHUNK +: CHUNK] = sum_w[k];
        end
    end

    // A running term walks the chain from the output side so adv is never read while being built.
    always_comb begin
        logic run;
        run         = out_ready;
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            run    = ~valid_q[k] | run;
            adv[k] = run;
        end
    end

    assign in_ready = adv[0];

    // NOTE: the stage data registers are reset too, so a flushed pipe presents all-zero outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            op_q    <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]    <= '0;
                beff_q[k] <= '0;
                res_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= stage_valid[k];
                end
                if (adv[k] && stage_valid[k]) begin
                    op_q[k]    <= stage_op[k];
                    carry_q[k] <= cout_w[k];
                    a_q[k]     <= stage_a[k];
                    beff_q[k]  <= stage_beff[k];
                    res_q[k]   <= res_d[k];
                end
            end
            if (adv[LAST] && stage_valid[LAST]) begin
                ovf_q  <= msbc_w[LAST] ^ cout_w[LAST];
                zero_q <= ~|res_d[LAST];
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign d         = res_q[LAST];
    assign ovf       = ovf_q;
    assign cb        = carry_q[LAST] ^ op_q[LAST];
    assign zero      = zero_q;

endmodule

// File: tb/tb_signed_addsub_pipe.sv
// Self-checking bench: four configurations share one stimulus stream; each has its own
// arithmetic reference model scoreboard, plus directed latency/flag/backpressure/reset cases.
module tb_signed_addsub_pipe;

    typedef struct packed {
        logic [15:0] d;
        logic        ovf;
        logic        cb;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        op;
    logic        out_ready;
    logic [15:0] a_w;
    logic [15:0] b_w;

    logic [3:0]  ir_all;
    logic [3:0]  ov_all;
    logic [3:0]  ovf_all;
    logic [3:0]  cb_all;
    logic [3:0]  zero_all;
    logic [5:0]  d0;
    logic [5:0]  d1;
    logic [7:0]  d2;
    logic [15:0] d3;
    logic [15:0] d_all [4];

    assign d_all[0] = {10'd0, d0};
    assign d_all[1] = {10'd0, d1};
    assign d_all[2] = {8'd0, d2};
    assign d_all[3] = d3;

    signed_addsub_pipe #(.WIDTH(6), .CHUNK(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_all[0]), .op(op),
        .a(a_w[5:0]), .b(b_w[5:0]), .out_valid(ov_all[0]), .out_ready(out_ready),
        .d(d0), .ovf(ovf_all[0]), .cb(cb_all[0]), .zero(zero_all[0]));

    signed_addsub_pipe #(.WIDTH(6), .CHUNK(6)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_all[1]), .op(op),
        .a(a_w[5:0]), .b(b_w[5:0]), .out_valid(ov_all[1]), .out_ready(out_ready),
        .d(d1), .ovf(ovf_all[1]), .cb(cb_all[1]), .zero(zero_all[1]));

    signed_addsub_pipe #(.WIDTH(8), .CHUNK(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_all[2]), .op(op),
        .a(a_w[7:0]), .b(b_w[7:0]), .out_valid(ov_all[2]), .out_ready(out_ready),
        .d(d2), .ovf(ovf_all[2]), .cb(cb_all[2]), .zero(zero_all[2]));

    signed_addsub_pipe #(.WIDTH(16), .CHUNK(1)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_all[3]), .op(op),
        .a(a_w), .b(b_w), .out_valid(ov_all[3]), .out_ready(out_ready),
        .d(d3), .ovf(ovf_all[3]), .cb(cb_all[3]), .zero(zero_all[3]));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int k);
        case (k)
            0:       return 6;
            1:       return 6;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    // Plain integer arithmetic: signed/unsigned interpretations of the operands at width w.
    function automatic exp_t model(input int w, input logic o, input logic [15:0] av, input logic [15:0] bv);
        longint m, ua, ub, sa, sbv, r;
        exp_t   e;
        m   = longint'(1) << w;
        ua  = longint'(av) % m;
        ub  = longint'(bv) % m;
        sa  = (ua >= m / 2) ? ua - m : ua;
        sbv = (ub >= m / 2) ? ub - m : ub;
        r   = o ? sa - sbv : sa + sbv;
        e.ovf  = (r < -(m / 2)) || (r >= m / 2);
        r      = ((r % m) + m) % m;
        e.d    = 16'(r);
        e.zero = (r == 0);
        e.cb   = o ? (ua < ub) : (ua + ub >= m);
        return e;
    endfunction

    exp_t        expq [4][$];
    logic [3:0]  stall_v = '0;
    logic [15:0] held_d [4];
    logic [2:0]  held_f [4];

    // Scoreboard: values at the falling edge equal those seen by the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int k = 0; k < 4; k++) expq[k].delete();
            stall_v = '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (stall_v[k]) begin
                    check($sformatf("hold_valid_dut%0d", k), ov_all[k], 1'b1);
                    check($sformatf("hold_out_dut%0d", k),
                          {d_all[k], ovf_all[k], cb_all[k], zero_all[k]}, {held_d[k], held_f[k]});
                end
                if (in_valid && ir_all[k])
                    expq[k].push_back(model(width_of(k), op, a_w, b_w));
                if (ov_all[k] && out_ready) begin
                    if (expq[k].size() == 0) begin
                        check($sformatf("spurious_out_dut%0d", k), 1'b1, 1'b0);
                    end else begin
                        e = expq[k].pop_front();
                        check($sformatf("d_dut%0d", k), d_all[k], e.d);
                        check($sformatf("ovf_dut%0d", k), ovf_all[k], e.ovf);
                        check($sformatf("cb_dut%0d", k), cb_all[k], e.cb);
                        check($sformatf("zero_dut%0d", k), zero_all[k], e.zero);
                    end
                end
                stall_v[k] = ov_all[k] && !out_ready;
                held_d[k]  = d_all[k];
                held_f[k]  = {ovf_all[k], cb_all[k], zero_all[k]};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic o, input logic [5:0] av, input logic [5:0] bv,
                           input logic [5:0] ed, input logic eovf, input logic ecb, input logic ez);
        int n;
        out_ready = 1'b1;
        op        = o;
        a_w       = {{10{av[5]}}, av};
        b_w       = {{10{bv[5]}}, bv};
        in_valid  = 1'b1;
        check({tag, "_in_ready"}, ir_all[0], 1'b1);
        step();
        in_valid = 1'b0;
        n = 1;
        while (!ov_all[0] && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_d"}, d0, ed);
        check({tag, "_ovf"}, ovf_all[0], eovf);
        check({tag, "_cb"}, cb_all[0], ecb);
        check({tag, "_zero"}, zero_all[0], ez);
        step();
    endtask

    initial begin
        int sent, emitted, cyc, first_low, seen;
        logic load;

        rst       = 1'b0;
        in_valid  = 1'b0;
        op        = 1'b0;
        a_w       = '0;
        b_w       = '0;
        out_ready = 1'b1;
        repeat (3) step();

        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_out_valid_dut%0d", k), ov_all[k], 1'b0);
            check($sformatf("reset_out_dut%0d", k),
                  {d_all[k], ovf_all[k], cb_all[k], zero_all[k]}, 19'd0);
        end
        rst = 1'b1;
        step();
        check("release_in_ready", ir_all, 4'hF);

        run_one("sub_5_3",      1'b1, 6'd5,  6'd3,  6'd2,  1'b0, 1'b0, 1'b0);
        run_one("add_ovf",      1'b0, 6'd31, 6'd1,  6'h20, 1'b1, 1'b0, 1'b0);
        run_one("sub_ovf",      1'b1, 6'h20, 6'd1,  6'h1F, 1'b1, 1'b0, 1'b0);
        run_one("sub_borrow",   1'b1, 6'd0,  6'd1,  6'h3F, 1'b0, 1'b1, 1'b0);
        run_one("sub_zero",     1'b1, 6'h39, 6'h39, 6'd0,  1'b0, 1'b0, 1'b1);
        repeat (20) step();

        // Backpressure: 8 beats, consumer stalled for cycles 2..6.
        sent      = 0;
        emitted   = 0;
        cyc       = 0;
        first_low = -1;
        load      = 1'b1;
        while (emitted < 8 && cyc < 80) begin
            out_ready = !(cyc >= 2 && cyc <= 6);
            if (sent < 8 && load) begin
                op  = 1'($urandom);
                a_w = 16'($urandom);
                b_w = 16'($urandom);
            end
            in_valid = (sent < 8);
            if (in_valid && !ir_all[0] && first_low < 0) first_low = sent;
            if (ov_all[0] && out_ready) emitted++;
            load = in_valid && ir_all[0];
            if (load) sent++;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_in_ready_drop_after", first_low, 3);
        check("bp_sent", sent, 8);
        check("bp_emitted", emitted, 8);
        repeat (20) step();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            op       = 1'($urandom);
            a_w      = 16'($urandom);
            b_w      = 16'($urandom);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("pre_reset_out_valid", ov_all[0], 1'b1);
        rst = 1'b0;
        #1;
        check("midreset_out_valid", ov_all[0], 1'b0);
        check("midreset_d", d0, 6'd0);
        step();
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (ov_all[0]) seen++;
            step();
        end
        check("post_reset_no_stale", seen, 0);
        run_one("post_reset_add", 1'b0, 6'h3E, 6'd5, 6'd3, 1'b0, 1'b1, 1'b0);
        repeat (20) step();

        // Random stream with random handshakes on both sides.
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            op        = 1'($urandom);
            a_w       = 16'($urandom);
            b_w       = ($urandom_range(0, 15) == 0) ? a_w : 16'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();
        for (int k = 0; k < 4; k++)
            check($sformatf("drained_dut%0d", k), expq[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
